multdiv_ctrl: RTL and testbench

Sequencing controller between the processor's execute stage and the shared multi-cycle multdiv unit.
- Accepts one mult/div request at a time from the pipeline.
- Holds the operands stable for the whole operation and issues a single-cycle start pulse.
- Stalls the pipeline until the unit reports ready, then produces one writeback beat.
- Maps unit exceptions and controller timeouts to a status-register write.

---
 rtl/multdiv_ctrl.sv | 176 +++++++++++++++++
 tb/tb_multdiv_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : multdiv_ctrl
//  Purpose  : Sequences one mult/div request from the execute stage through
//             the shared multi-cycle multdiv unit: latches operands, pulses
//             the start control, stalls the pipeline until the unit is ready
//             (or a timeout expires) and emits one registered writeback beat.
//  Revision : 1.0 - initial release
// ============================================================================
module multdiv_ctrl #(
    parameter int          TIMEOUT       = 48,
    parameter logic [4:0]  EXC_RD        = 5'd30,
    parameter logic [31:0] EXC_MULT_CODE = 32'd4,
    parameter logic [31:0] EXC_DIV_CODE  = 32'd5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic        issue_op,
    input  logic [31:0] issue_a,
    input  logic [31:0] issue_b,
    input  logic [4:0]  issue_rd,
    input  logic        flush,
    output logic [31:0] md_operandA,
    output logic [31:0] md_operandB,
    output logic        md_ctrl_MULT,
    output logic        md_ctrl_DIV,
    output logic        md_enable,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_resultRDY,
    output logic        stall,
    output logic        busy,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] BUSY  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic             op_q;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    logic [4:0]       rd_q;
    logic [31:0]      result_q;
    logic             exc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             wb_valid_q;
    logic [4:0]       wb_rd_q;
    logic [31:0]      wb_data_q;

    logic             w_accept;
    logic             w_timeout;

    // A request is taken only in IDLE and only when it is not being squashed
    assign w_accept  = (state_q == IDLE) && issue_valid && !flush;
    // Timeout fires on the last allowed BUSY cycle; a simultaneous ready wins
    assign w_timeout = (state_q == BUSY) && (cnt_q == CNT_LAST) && !md_resultRDY;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides every other transition
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (w_accept) state_d = START;
            START:   state_d = BUSY;
            BUSY:    if (md_resultRDY || w_timeout) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
        end
    end

    // State-decoded outputs toward the unit and the pipeline
    always_comb begin
        stall        = 1'b0;
        busy         = (state_q != IDLE);
        md_enable    = 1'b0;
        md_ctrl_MULT = 1'b0;
        md_ctrl_DIV  = 1'b0;
        case (state_q)
            IDLE: begin
                stall = issue_valid;
            end
            START: begin
                stall        = 1'b1;
                md_enable    = 1'b1;
                md_ctrl_MULT = !op_q;
                md_ctrl_DIV  = op_q;
            end
            BUSY: begin
                stall     = 1'b1;
                md_enable = 1'b1;
            end
            default: begin
                stall = 1'b0;
            end
        endcase
    end

    // Operands always come from the latches so the unit never sees them move
    assign md_operandA = a_q;
    assign md_operandB = b_q;

    assign wb_valid = wb_valid_q;
    assign wb_rd    = wb_rd_q;
    assign wb_data  = wb_data_q;

    // Operand latch, timeout counter, result capture and writeback register
    always_ff @(posedge clock) begin
        if (reset) begin
            op_q       <= 1'b0;
            a_q        <= 32'd0;
            b_q        <= 32'd0;
            rd_q       <= 5'd0;
            result_q   <= 32'd0;
            exc_q      <= 1'b0;
            cnt_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_data_q  <= 32'd0;
        end else begin
            wb_valid_q <= 1'b0;
            if (w_accept) begin
                op_q <= issue_op;
                a_q  <= issue_a;
                b_q  <= issue_b;
                rd_q <= issue_rd;
            end
            if (state_q == START) begin
                cnt_q <= '0;
            end
            if (state_q == BUSY) begin
                cnt_q <= cnt_q + CNT_W'(1);
                if (md_resultRDY) begin
                    result_q <= md_result;
                    exc_q    <= md_exception;
                end else if (w_timeout) begin
                    exc_q <= 1'b1;
                end
            end
            // Beat is launched from DONE; a squash in DONE drops it
            if ((state_q == DONE) && !flush) begin
                if (exc_q) begin
                    wb_valid_q <= 1'b1;
                    wb_rd_q    <= EXC_RD;
                    wb_data_q  <= op_q ? EXC_DIV_CODE : EXC_MULT_CODE;
                end else if (rd_q != 5'd0) begin
                    wb_valid_q <= 1'b1;
                    wb_rd_q    <= rd_q;
                    wb_data_q  <= result_q;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multdiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multdiv_ctrl
//  Purpose  : Self-checking bench for multdiv_ctrl with a behavioural multdiv
//             stub and a writeback scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multdiv_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        issue_valid = 1'b0;
    logic        issue_op = 1'b0;
    logic [31:0] issue_a = 32'd0;
    logic [31:0] issue_b = 32'd0;
    logic [4:0]  issue_rd = 5'd0;
    logic        flush = 1'b0;
    logic [31:0] md_operandA;
    logic [31:0] md_operandB;
    logic        md_ctrl_MULT;
    logic        md_ctrl_DIV;
    logic        md_enable;
    logic [31:0] md_result = 32'd0;
    logic        md_exception = 1'b0;
    logic        md_resultRDY = 1'b0;
    logic        stall;
    logic        busy;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int total = 0;
    int bad   = 0;
    logic [36:0] sb_q[$];

    multdiv_ctrl dut (
        .clock        (clock),
        .reset        (reset),
        .issue_valid  (issue_valid),
        .issue_op     (issue_op),
        .issue_a      (issue_a),
        .issue_b      (issue_b),
        .issue_rd     (issue_rd),
        .flush        (flush),
        .md_operandA  (md_operandA),
        .md_operandB  (md_operandB),
        .md_ctrl_MULT (md_ctrl_MULT),
        .md_ctrl_DIV  (md_ctrl_DIV),
        .md_enable    (md_enable),
        .md_result    (md_result),
        .md_exception (md_exception),
        .md_resultRDY (md_resultRDY),
        .stall        (stall),
        .busy         (busy),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data)
    );

    always #5 clock = ~clock;

    // Behavioural multdiv unit: signed mult/div with overflow / div-by-zero exceptions
    function automatic logic [32:0] unit_calc(input logic d, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] p;
        logic signed [31:0] q;
        logic               e;
        if (!d) begin
            p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            e = (p != {{32{p[31]}}, p[31:0]});
            return {e, p[31:0]};
        end
        if (b == 32'd0) return {1'b1, 32'd0};
        q = $signed(a) / $signed(b);
        return {1'b0, q};
    endfunction

    bit stub_stuck = 1'b0;
    bit stub_active = 1'b0;
    bit stub_div = 1'b0;
    int stub_cnt = 0;

    always @(posedge clock) begin
        if (reset || !md_enable) begin
            stub_active  <= 1'b0;
            stub_cnt     <= 0;
            md_resultRDY <= 1'b0;
            md_exception <= 1'b0;
            md_result    <= 32'd0;
        end else if (md_ctrl_MULT || md_ctrl_DIV) begin
            stub_active  <= 1'b1;
            stub_div     <= md_ctrl_DIV;
            stub_cnt     <= 0;
            md_resultRDY <= 1'b0;
        end else if (stub_active) begin
            stub_cnt <= stub_cnt + 1;
            if (!stub_stuck && (stub_cnt + 1 == (stub_div ? 33 : 16))) begin
                md_resultRDY <= 1'b1;
                {md_exception, md_result} <= unit_calc(stub_div, md_operandA, md_operandB);
            end
        end
    end

    // Writeback monitor: every beat must match the oldest expected entry
    always @(negedge clock) begin
        if (!reset && wb_valid) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL wb_unexpected: got rd=%0d data=%h, required no writeback", wb_rd, wb_data);
            end else begin
                logic [36:0] exp;
                exp = sb_q.pop_front();
                if ({wb_rd, wb_data} !== exp) begin
                    bad++;
                    $display("FAIL wb_beat: got rd=%0d data=%h, required rd=%0d data=%h",
                             wb_rd, wb_data, exp[36:32], exp[31:0]);
                end
            end
        end
    end

    function automatic logic [106:0] outs_vec();
        return {md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV, md_enable,
                stall, busy, wb_valid, wb_rd, wb_data};
    endfunction

    // Present one request and hold it until stall drops (DONE) or the bound expires
    task automatic do_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input bit toggle,
                         output int mp, output int dp, output int bcyc,
                         output bit stable, output bit done_ok);
        mp = 0; dp = 0; bcyc = 0; stable = 1'b1; done_ok = 1'b0;
        @(negedge clock);
        issue_op = op; issue_a = a; issue_b = b; issue_rd = rd; issue_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clock);
            if (md_ctrl_MULT) mp++;
            if (md_ctrl_DIV) dp++;
            if (md_enable && !md_ctrl_MULT && !md_ctrl_DIV) bcyc++;
            if (busy && (md_operandA !== a || md_operandB !== b)) stable = 1'b0;
            if (!stall) begin
                done_ok = busy;
                break;
            end
            if (toggle) issue_a = ~issue_a;
        end
        issue_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        repeat (4) @(negedge clock);
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: got %0d pending writebacks, required 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        total++;
        if (outs_vec() !== '0) begin
            bad++; $display("FAIL reset_outputs: got %h, required 0", outs_vec());
        end
        reset = 1'b0;
        @(negedge clock);
        total++;
        if (outs_vec() !== '0) begin
            bad++; $display("FAIL idle_outputs: got %h, required 0", outs_vec());
        end
    endtask

    task automatic test_mult();
        int mp, dp, bc; bit st, ok;
        sb_q.push_back({5'd3, 32'd42});
        do_op(1'b0, 32'd7, 32'd6, 5'd3, 1'b0, mp, dp, bc, st, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL mult_done: got done=%0d, required 1", ok); end
        total++;
        if (mp != 1 || dp != 0) begin
            bad++; $display("FAIL mult_pulse: got mult=%0d div=%0d, required 1/0", mp, dp);
        end
        drain("mult");
    endtask

    task automatic test_div_hold();
        int mp, dp, bc; bit st, ok;
        sb_q.push_back({5'd9, 32'hFFFF_FFFA});
        do_op(1'b1, 32'hFFFF_FFEC, 32'd3, 5'd9, 1'b1, mp, dp, bc, st, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL div_done: got done=%0d, required 1", ok); end
        total++;
        if (dp != 1 || mp != 0) begin
            bad++; $display("FAIL div_pulse: got mult=%0d div=%0d, required 0/1", mp, dp);
        end
        total++;
        if (!st) begin bad++; $display("FAIL operand_hold: got stable=%0d, required 1", st); end
        drain("div");
    endtask

    task automatic test_exceptions();
        int mp, dp, bc; bit st, ok;
        sb_q.push_back({5'd30, 32'd5});
        do_op(1'b1, 32'd5, 32'd0, 5'd4, 1'b0, mp, dp, bc, st, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL divzero_done: got done=%0d, required 1", ok); end
        drain("divzero");
        sb_q.push_back({5'd30, 32'd4});
        do_op(1'b0, 32'h0001_0000, 32'h0001_0000, 5'd4, 1'b0, mp, dp, bc, st, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL overflow_done: got done=%0d, required 1", ok); end
        drain("overflow");
    endtask

    task automatic test_timeout();
        int mp, dp, bc; bit st, ok;
        stub_stuck = 1'b1;
        sb_q.push_back({5'd30, 32'd5});
        do_op(1'b1, 32'd100, 32'd7, 5'd7, 1'b0, mp, dp, bc, st, ok);
        stub_stuck = 1'b0;
        total++;
        if (!ok) begin bad++; $display("FAIL timeout_done: got done=%0d, required 1", ok); end
        total++;
        if (bc != 48) begin bad++; $display("FAIL timeout_cycles: got %0d busy cycles, required 48", bc); end
        drain("timeout");
    endtask

    task automatic test_flush();
        int mp, dp, bc; bit st, ok;
        int nb;
        nb = 0;
        @(negedge clock);
        issue_op = 1'b1; issue_a = 32'd50; issue_b = 32'd5; issue_rd = 5'd2; issue_valid = 1'b1;
        for (int n = 0; n < 50 && nb < 5; n++) begin
            @(negedge clock);
            if (md_enable && !md_ctrl_MULT && !md_ctrl_DIV) nb++;
        end
        total++;
        if (nb != 5) begin bad++; $display("FAIL flush_reach_busy: got %0d busy cycles, required 5", nb); end
        flush = 1'b1; issue_valid = 1'b0;
        @(negedge clock);
        flush = 1'b0;
        total++;
        if (busy !== 1'b0 || md_enable !== 1'b0) begin
            bad++; $display("FAIL flush_idle: got busy=%b enable=%b, required 0/0", busy, md_enable);
        end
        repeat (40) @(negedge clock);
        sb_q.push_back({5'd1, 32'd9});
        do_op(1'b0, 32'd3, 32'd3, 5'd1, 1'b0, mp, dp, bc, st, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL after_flush_done: got done=%0d, required 1", ok); end
        drain("after_flush");
    endtask

    task automatic test_idle_flush();
        @(negedge clock);
        issue_op = 1'b0; issue_a = 32'd2; issue_b = 32'd2; issue_rd = 5'd6;
        issue_valid = 1'b1; flush = 1'b1;
        repeat (2) @(negedge clock);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL idle_flush: got busy=%b, required 0", busy); end
        issue_valid = 1'b0; flush = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_reset_mid();
        int mp, dp, bc; bit st, ok;
        int nb;
        nb = 0;
        @(negedge clock);
        issue_op = 1'b0; issue_a = 32'd2; issue_b = 32'd2; issue_rd = 5'd5; issue_valid = 1'b1;
        for (int n = 0; n < 50 && nb < 3; n++) begin
            @(negedge clock);
            if (md_enable && !md_ctrl_MULT && !md_ctrl_DIV) nb++;
        end
        reset = 1'b1; issue_valid = 1'b0;
        @(negedge clock);
        total++;
        if (outs_vec() !== '0) begin
            bad++; $display("FAIL reset_mid_outputs: got %h, required 0", outs_vec());
        end
        reset = 1'b0;
        @(negedge clock);
        do_op(1'b0, 32'd5, 32'd5, 5'd0, 1'b0, mp, dp, bc, st, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL rd0_done: got done=%0d, required 1", ok); end
        drain("rd0");
    endtask

    task automatic test_back_to_back();
        int mp, dp, bc; bit st, ok;
        sb_q.push_back({5'd10, 32'd12});
        do_op(1'b0, 32'd3, 32'd4, 5'd10, 1'b0, mp, dp, bc, st, ok);
        sb_q.push_back({5'd11, 32'hFFFF_FFFE});
        do_op(1'b1, 32'hFFFF_FFF9, 32'd3, 5'd11, 1'b0, mp, dp, bc, st, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL b2b_done: got done=%0d, required 1", ok); end
        drain("b2b");
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div_hold();
        test_exceptions();
        test_timeout();
        test_flush();
        test_idle_flush();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
